snn_event_arb_fifo: RTL and testbench

//  Multi-source successor to the single-stream capture->convolution event link. It merges
//  NUM_SRC spike-event streams into one with round-robin arbitration. Each accepted event is

---
 rtl/snn_event_arb_fifo_pkg.sv | 17 +
 rtl/snn_rr_arbiter.sv | 36 +++
 rtl/snn_event_arb_fifo.sv | 91 +++++++++
 tb/tb_snn_event_arb_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_event_arb_fifo_pkg.sv
// snn_event_arb_fifo_pkg: shared event types and width helpers for the multi-source event link
package snn_event_arb_fifo_pkg;
  localparam int COORD_W_DEF = 8;
  localparam int NUM_SRC_DEF = 4;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int SRC_W_DEF = src_w(NUM_SRC_DEF);
  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } vec2_t;
  typedef struct packed {
    logic [SRC_W_DEF-1:0] src;
    vec2_t                coord;
  } src_event_t;
endpackage

// File: rtl/snn_rr_arbiter.sv
// snn_rr_arbiter: round-robin grant of the first requester at or after rr_ptr
module snn_rr_arbiter
  import snn_event_arb_fifo_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = src_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] rr_ptr;
  logic          found;
  int            idx;
  always_comb begin
    gnt_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    gnt = (found && en) ? (N'(1) << gnt_idx) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (adv) rr_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  end
endmodule

// File: rtl/snn_event_arb_fifo.sv
// snn_event_arb_fifo: round-robin merge of spike streams into a range-checked FWFT FIFO with credit-limited output
module snn_event_arb_fifo
  import snn_event_arb_fifo_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int COORD_W   = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 16,
  localparam int SW = src_w(NUM_SRC),
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
  localparam int OW = $clog2(MAX_OUTST + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*COORD_W-1:0] src_x,
  input  logic [NUM_SRC*COORD_W-1:0] src_y,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       evt_valid,
  output logic [COORD_W-1:0]         evt_x,
  output logic [COORD_W-1:0]         evt_y,
  output logic [SW-1:0]              evt_src,
  input  logic                       evt_ready,
  input  logic                       evt_ack,
  output logic [LW-1:0]              fifo_level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       ack_err
);
  typedef struct packed {
    logic [SW-1:0]      src;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } entry_t;
  entry_t             mem [DEPTH];
  entry_t             head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [OW-1:0]      outst;
  logic [SW-1:0]      gnt_idx;
  logic [COORD_W-1:0] sx, sy;
  logic               push_hs, in_range, push, pop, empty;
  snn_rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (src_valid),
    .en      (fifo_level < LW'(DEPTH)),
    .adv     (push_hs),
    .gnt     (src_ready),
    .gnt_idx (gnt_idx)
  );
  always_comb begin
    sx = src_x[gnt_idx*COORD_W +: COORD_W];
    sy = src_y[gnt_idx*COORD_W +: COORD_W];
    push_hs = |(src_valid & src_ready);
    in_range = (32'(sx) < IMG_W) && (32'(sy) < IMG_H);
    push = push_hs && in_range;
    empty = fifo_level == '0;
    evt_valid = !empty && (32'(outst) < MAX_OUTST);
    pop = evt_valid && evt_ready;
    head = mem[rd_ptr];
    evt_x = empty ? '0 : head.x;
    evt_y = empty ? '0 : head.y;
    evt_src = empty ? '0 : head.src;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{src: gnt_idx, x: sx, y: sy};
  end
  // Outstanding credits only move on pop xor ack; an ack with nothing in flight is flagged instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      outst <= '0;
      drop_cnt <= '0;
      ack_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
      if (push_hs && !in_range && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (pop && !evt_ack) outst <= outst + OW'(1);
      else if (!pop && evt_ack && outst != '0) outst <= outst - OW'(1);
      if (!pop && evt_ack && outst == '0) ack_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_snn_event_arb_fifo.sv
// tb_snn_event_arb_fifo: directed scenarios plus randomized traffic against a queue-based reference model
module tb_snn_event_arb_fifo;
  localparam int NUM_SRC = 4, COORD_W = 8, IMG_W = 32, IMG_H = 32, DEPTH = 16, MAX_OUTST = 4, CNT_W = 16;
  logic                       clk = 1'b0, rst = 1'b1;
  logic [NUM_SRC-1:0]         src_valid = '0;
  logic [NUM_SRC*COORD_W-1:0] src_x = '0, src_y = '0;
  logic [NUM_SRC-1:0]         src_ready;
  logic                       evt_valid, evt_ready = 1'b0, evt_ack = 1'b0, ack_err;
  logic [COORD_W-1:0]         evt_x, evt_y;
  logic [1:0]                 evt_src;
  logic [4:0]                 fifo_level;
  logic [CNT_W-1:0]           drop_cnt;
  int n_pass = 0, n_total = 0;

  snn_event_arb_fifo dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_x(src_x), .src_y(src_y),
    .src_ready(src_ready), .evt_valid(evt_valid), .evt_x(evt_x), .evt_y(evt_y),
    .evt_src(evt_src), .evt_ready(evt_ready), .evt_ack(evt_ack),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {int src; int x; int y;} ev_t;
  ev_t mq[$];
  int  m_rr, m_outst, m_drop;
  bit  m_err;

  function automatic int m_grant();
    if (mq.size() >= DEPTH) return -1;
    for (int k = 0; k < NUM_SRC; k++)
      if (src_valid[(m_rr + k) % NUM_SRC]) return (m_rr + k) % NUM_SRC;
    return -1;
  endfunction

  function automatic logic [NUM_SRC-1:0] m_ready();
    int g;
    g = m_grant();
    return (g >= 0) ? NUM_SRC'(1 << g) : '0;
  endfunction

  function automatic bit m_valid();
    return mq.size() > 0 && m_outst < MAX_OUTST;
  endfunction

  task automatic model_step();
    int g, sx, sy;
    bit pop;
    g = m_grant();
    pop = m_valid() && evt_ready;
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      m_rr = (g + 1) % NUM_SRC;
      sx = int'(src_x[g*COORD_W +: COORD_W]);
      sy = int'(src_y[g*COORD_W +: COORD_W]);
      if (sx < IMG_W && sy < IMG_H) mq.push_back('{g, sx, sy});
      else if (m_drop < (1 << CNT_W) - 1) m_drop++;
    end
    if (pop && !evt_ack) m_outst++;
    else if (!pop && evt_ack) begin
      if (m_outst > 0) m_outst--;
      else m_err = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; evt_ready = 1'b0; evt_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); m_rr = 0; m_outst = 0; m_drop = 0; m_err = 1'b0;
  endtask

  task automatic set_src(input int s, input int x, input int y);
    src_x[s*COORD_W +: COORD_W] = COORD_W'(x);
    src_y[s*COORD_W +: COORD_W] = COORD_W'(y);
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) set_src(s, s, 40);
    src_valid = 4'b1111; evt_ready = 1'b1; evt_ack = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    do_reset();
    #1;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid got %b exp 0", evt_valid); else n_pass++;
    n_total++; if (fifo_level !== 5'd0) $display("FAIL reset_level got %0d exp 0", fifo_level); else n_pass++;
    n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got %0d exp 0", drop_cnt); else n_pass++;
    n_total++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err got %b exp 0", ack_err); else n_pass++;
    n_total++; if (src_ready !== 4'b0) $display("FAIL reset_src_ready got %b exp 0", src_ready); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) set_src(s, s + 1, s + 2);
    src_valid = 4'b1111; evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      evt_ack = (i > 0);
      #1;
      n_total++;
      if (src_ready !== 4'(1 << (i % 4))) $display("FAIL rr_grant cyc %0d got %b exp %b", i, src_ready, 4'(1 << (i % 4)));
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (evt_valid !== 1'b1 || evt_src !== 2'((i - 1) % 4))
          $display("FAIL rr_evt_src cyc %0d got v=%b src=%0d exp v=1 src=%0d", i, evt_valid, evt_src, (i - 1) % 4);
        else n_pass++;
      end
      tick();
    end
    src_valid = '0; evt_ack = 1'b0;
  endtask

  task automatic test_range_drop();
    do_reset();
    src_valid = 4'b0001; set_src(0, 32, 5);
    #1;
    n_total++; if (src_ready !== 4'b0001) $display("FAIL drop_handshake got %b exp 0001", src_ready); else n_pass++;
    tick();
    set_src(0, 31, 31);
    #1;
    n_total++; if (evt_valid !== 1'b0 || drop_cnt !== 16'd1) $display("FAIL drop_first got v=%b drop=%0d exp v=0 drop=1", evt_valid, drop_cnt); else n_pass++;
    tick();
    src_valid = '0;
    #1;
    n_total++;
    if (evt_valid !== 1'b1 || evt_x !== 8'd31 || evt_y !== 8'd31 || evt_src !== 2'd0 || fifo_level !== 5'd1 || drop_cnt !== 16'd1)
      $display("FAIL drop_kept got v=%b x=%0d y=%0d src=%0d lvl=%0d drop=%0d exp 1,31,31,0,1,1", evt_valid, evt_x, evt_y, evt_src, fifo_level, drop_cnt);
    else n_pass++;
  endtask

  task automatic test_full();
    int acc;
    do_reset();
    acc = 0; src_valid = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      set_src(1, i, i);
      #1;
      if (src_ready[1]) acc++;
      tick();
    end
    n_total++; if (acc != 16) $display("FAIL full_accepted got %0d exp 16", acc); else n_pass++;
    n_total++; if (fifo_level !== 5'd16 || src_ready !== 4'b0) $display("FAIL full_level got lvl=%0d rdy=%b exp 16,0000", fifo_level, src_ready); else n_pass++;
    evt_ready = 1'b1;
    #1;
    n_total++; if (src_ready !== 4'b0 || evt_valid !== 1'b1 || evt_x !== 8'd0) $display("FAIL full_pop_cycle got rdy=%b v=%b x=%0d exp 0000,1,0", src_ready, evt_valid, evt_x); else n_pass++;
    tick();
    evt_ready = 1'b0;
    #1;
    n_total++; if (fifo_level !== 5'd15 || src_ready !== 4'b0010) $display("FAIL full_after_pop got lvl=%0d rdy=%b exp 15,0010", fifo_level, src_ready); else n_pass++;
    tick();
    src_valid = '0;
    #1;
    n_total++; if (fifo_level !== 5'd16) $display("FAIL full_refill got %0d exp 16", fifo_level); else n_pass++;
  endtask

  task automatic test_credit();
    int pops;
    do_reset();
    src_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin set_src(2, i, 1); tick(); end
    src_valid = '0; evt_ready = 1'b1; pops = 0;
    for (int i = 0; i < 10; i++) begin #1; if (evt_valid) pops++; tick(); end
    n_total++; if (pops != 4) $display("FAIL credit_pops got %0d exp 4", pops); else n_pass++;
    n_total++; if (evt_valid !== 1'b0 || fifo_level !== 5'd4) $display("FAIL credit_stall got v=%b lvl=%0d exp 0,4", evt_valid, fifo_level); else n_pass++;
    evt_ack = 1'b1; tick(); evt_ack = 1'b0; pops = 0;
    for (int i = 0; i < 5; i++) begin #1; if (evt_valid) pops++; tick(); end
    n_total++; if (pops != 1) $display("FAIL credit_after_ack got %0d exp 1", pops); else n_pass++;
  endtask

  task automatic test_ack_err();
    int pops;
    do_reset();
    evt_ack = 1'b1;
    #1;
    n_total++; if (ack_err !== 1'b0) $display("FAIL ack_err_pre got %b exp 0", ack_err); else n_pass++;
    tick(); evt_ack = 1'b0;
    #1;
    n_total++; if (ack_err !== 1'b1) $display("FAIL ack_err_set got %b exp 1", ack_err); else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_total++; if (ack_err !== 1'b1) $display("FAIL ack_err_sticky got %b exp 1", ack_err); else n_pass++;
    do_reset();
    src_valid = 4'b1000;
    for (int i = 0; i < 6; i++) begin set_src(3, i, 2); tick(); end
    src_valid = '0; evt_ready = 1'b1;
    tick(); tick();
    evt_ack = 1'b1; tick(); evt_ack = 1'b0; pops = 0;
    for (int i = 0; i < 6; i++) begin #1; if (evt_valid) pops++; tick(); end
    n_total++;
    if (pops != 2 || fifo_level !== 5'd1 || ack_err !== 1'b0)
      $display("FAIL popack_outst got pops=%0d lvl=%0d err=%b exp 2,1,0", pops, fifo_level, ack_err);
    else n_pass++;
  endtask

  task automatic test_random();
    bit bad;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      src_valid = NUM_SRC'($urandom_range(0, 15));
      for (int s = 0; s < NUM_SRC; s++) set_src(s, $urandom_range(0, 36), $urandom_range(0, 36));
      evt_ready = ($urandom_range(0, 3) != 0);
      evt_ack = ($urandom_range(0, 2) == 0);
      #1;
      n_total++;
      if (src_ready !== m_ready()) $display("FAIL rand_ready cyc %0d got %b exp %b", i, src_ready, m_ready()); else n_pass++;
      bad = (evt_valid !== m_valid());
      if (!bad && m_valid())
        bad = (evt_x !== 8'(mq[0].x)) || (evt_y !== 8'(mq[0].y)) || (evt_src !== 2'(mq[0].src));
      n_total++;
      if (bad) $display("FAIL rand_head cyc %0d got v=%b x=%0d y=%0d src=%0d exp v=%b", i, evt_valid, evt_x, evt_y, evt_src, m_valid());
      else n_pass++;
      n_total++;
      if (fifo_level !== 5'(mq.size()) || drop_cnt !== 16'(m_drop) || ack_err !== m_err)
        $display("FAIL rand_status cyc %0d got lvl=%0d drop=%0d err=%b exp %0d,%0d,%b", i, fifo_level, drop_cnt, ack_err, mq.size(), m_drop, m_err);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_range_drop();
    test_full();
    test_credit();
    test_ack_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
